// File: rtl/vc_flit_tx.sv
// vc_flit_tx: credit-based head/body/tail flit framer feeding a downstream VC FIFO
module vc_flit_tx #(
    parameter int DEPTH = 32,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pkt_valid,
    output logic          pkt_ready,
    input  logic [7:0]    pkt_dest,
    input  logic [3:0]    pkt_len,
    input  logic          pay_valid,
    output logic          pay_ready,
    input  logic [7:0]    pay_data,
    output logic [9:0]    flit_out,
    output logic          flit_write_en,
    input  logic          credit_in,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          error
);
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
    state_t     state;
    logic [7:0] dest;
    logic [3:0] len;
    logic [3:0] remaining;
    logic       has_credit;
    logic       send_head;
    logic       send_body;
    logic       send;

    // handshakes and send decisions; a credit arriving this cycle is not usable yet
    always_comb begin
        has_credit = credits != '0;
        pkt_ready  = state == IDLE;
        pay_ready  = state == BODY && has_credit;
        send_head  = state == HEAD && has_credit;
        send_body  = pay_valid && pay_ready;
        send       = send_head || send_body;
    end

    assign busy = state != IDLE;

    // framing FSM with registered flit outputs; reset abandons any packet in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            dest          <= '0;
            len           <= '0;
            remaining     <= '0;
            flit_out      <= '0;
            flit_write_en <= 1'b0;
        end else begin
            flit_write_en <= send;
            case (state)
                IDLE: if (pkt_valid) begin
                    dest  <= pkt_dest;
                    len   <= pkt_len;
                    state <= HEAD;
                end
                HEAD: if (send_head) begin
                    flit_out  <= {len == 4'd0 ? 2'b11 : 2'b01, dest};
                    remaining <= len;
                    state     <= len == 4'd0 ? IDLE : BODY;
                end
                BODY: if (send_body) begin
                    flit_out  <= {remaining == 4'd1 ? 2'b10 : 2'b00, pay_data};
                    remaining <= remaining - 4'd1;
                    if (remaining == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // credit accounting: spend on send, refund on credit_in, saturate and flag overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= CW'(DEPTH);
            error   <= 1'b0;
        end else if (credit_in && !send) begin
            if (credits == CW'(DEPTH)) error <= 1'b1;
            else credits <= credits + CW'(1);
        end else if (send && !credit_in) begin
            credits <= credits - CW'(1);
        end
    end
endmodule
